frv_shfl_iter: RTL

- Iterative multi-cycle functional unit computing the Bitmanip shfl/unshfl/shfli/unshfli result.
- Sits in the execute stage: decode supplies rs1, the 4-bit control (rs2[3:0] or insn[23:20]) and direction. The result goes to writeback and from there onto the RVFI retirement trace checked by the shfl instruction checker.
- Applies one butterfly stage per cycle, trading latency for area against a single-cycle 4-stage network.

---
 rtl/frv_shfl_iter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/frv_shfl_iter.sv
// Iterative Bitmanip shfl/unshfl unit: applies one butterfly stage per cycle
// to an accumulator, in 8-4-2-1 order for shfl and 1-2-4-8 order for unshfl.
module frv_shfl_iter #(
   parameter bit SKIP_DISABLED = 1'b1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rs1,
   input  logic [3:0]  in_ctrl,
   input  logic        in_unshfl,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [1:0]  dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // flush overrides any request presented in the same cycle.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] acc, acc_nxt;
   logic [3:0]  rem, rem_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic        dir, dir_nxt;

   logic [1:0]  sel_k;
   logic        sel_en;
   logic        last;
   logic [3:0]  clr;

   // Stage k moves bits by N = 2^k; k=3 is the 8-stage, k=0 the 1-stage.
   function automatic logic [31:0] stage(input logic [31:0] x, input logic [1:0] k);
      logic [31:0] l, r, y;
      case (k)
         2'd3: begin
            l = 32'h00ff0000; r = 32'h0000ff00;
            y = (x & ~(l | r)) | ((x << 8) & l) | ((x >> 8) & r);
         end
         2'd2: begin
            l = 32'h0f000f00; r = 32'h00f000f0;
            y = (x & ~(l | r)) | ((x << 4) & l) | ((x >> 4) & r);
         end
         2'd1: begin
            l = 32'h30303030; r = 32'h0c0c0c0c;
            y = (x & ~(l | r)) | ((x << 2) & l) | ((x >> 2) & r);
         end
         default: begin
            l = 32'h44444444; r = 32'h22222222;
            y = (x & ~(l | r)) | ((x << 1) & l) | ((x >> 1) & r);
         end
      endcase
      return y;
   endfunction

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state <= IDLE;
         acc   <= 32'h0;
         rem   <= 4'h0;
         cnt   <= 2'd0;
         dir   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         rem   <= rem_nxt;
         cnt   <= cnt_nxt;
         dir   <= dir_nxt;
      end
   end

   // Stage selection for the current RUN cycle.
   always_comb begin
      sel_k  = 2'd0;
      sel_en = 1'b0;
      last   = 1'b0;
      if (SKIP_DISABLED) begin
         if (!dir) begin
            if (rem[3])      begin sel_k = 2'd3; sel_en = 1'b1; end
            else if (rem[2]) begin sel_k = 2'd2; sel_en = 1'b1; end
            else if (rem[1]) begin sel_k = 2'd1; sel_en = 1'b1; end
            else if (rem[0]) begin sel_k = 2'd0; sel_en = 1'b1; end
         end else begin
            if (rem[0])      begin sel_k = 2'd0; sel_en = 1'b1; end
            else if (rem[1]) begin sel_k = 2'd1; sel_en = 1'b1; end
            else if (rem[2]) begin sel_k = 2'd2; sel_en = 1'b1; end
            else if (rem[3]) begin sel_k = 2'd3; sel_en = 1'b1; end
         end
         clr  = sel_en ? (4'b0001 << sel_k) : 4'b0000;
         last = ((rem & ~clr) == 4'b0000);
      end else begin
         sel_k  = dir ? cnt : ~cnt;
         sel_en = rem[sel_k];
         clr    = 4'b0000;
         last   = (cnt == 2'd3);
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      rem_nxt   = rem;
      cnt_nxt   = cnt;
      dir_nxt   = dir;
      case (state)
         IDLE: begin
            if (in_valid && !flush) begin
               acc_nxt   = in_rs1;
               rem_nxt   = in_ctrl;
               dir_nxt   = in_unshfl;
               cnt_nxt   = 2'd0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (sel_en) acc_nxt = stage(acc, sel_k);
            rem_nxt = rem & ~clr;
            cnt_nxt = cnt + 2'd1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign out_result = acc;
   assign dbg_state  = state;

endmodule
